// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: serial line in, byte/valid/ready handshake
// and error pulses out. The receiver takes the master view.
interface uart_rx_if;
    logic       rx;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rx,
        input  ready,
        output dout,
        output valid,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx,
        output ready,
        input  dout,
        input  valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register
// and valid/ready hand-off plus framing-error and overrun pulses.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 2604
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int              CW      = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0]   HALF_LD = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0]   FULL_LD = CW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rx_prev_q;
    logic [1:0]    fill_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    dout_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          overrun_q;

    logic          rx_s;
    logic          fall_s;
    logic          cnt_zero_s;
    logic          take_s;
    logic [7:0]    shift_d;

    // Edge detect, counter terminal and shift helpers.
    always_comb begin
        rx_s       = sync2_q;
        fall_s     = fill_q[1] & rx_prev_q & ~rx_s;
        cnt_zero_s = (cnt_q == {CW{1'b0}});
        take_s     = valid_q & bus.ready;
        shift_d    = {rx_s, shift_q[7:1]};
    end

    // Line synchronizer; fill_q masks the reset value of the flops so a line
    // held low through reset release is not mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            fill_q    <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync1_q   <= bus.rx;
            sync2_q   <= sync1_q;
            fill_q    <= {fill_q[0], 1'b1};
            rx_prev_q <= fill_q[1] & rx_s;
        end
    end

    // Receive FSM with bit timer, holding register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            dout_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (take_s) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fall_s) begin
                        state_q <= START;
                        cnt_q   <= HALF_LD;
                    end
                end
                START: begin
                    if (!cnt_zero_s) begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end else if (!rx_s) begin
                        state_q <= DATA;
                        cnt_q   <= FULL_LD;
                        idx_q   <= 3'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!cnt_zero_s) begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        shift_q <= shift_d;
                        idx_q   <= idx_q + 3'd1;
                        cnt_q   <= FULL_LD;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!cnt_zero_s) begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        state_q <= IDLE;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                        end else if (!valid_q || bus.ready) begin
                            // A same-cycle consume frees the register for the new byte.
                            dout_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a vector table, hand-written corner
// sequences and a randomized frame stream checked against an in-order byte model.
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int CPB2 = 2604;

    logic clk;
    logic rst;
    logic rx1, ready1, rx2, ready2;
    int   cyc;
    int   n_tests, n_fail;

    uart_rx_if bus1();
    uart_rx_if bus2();
    assign bus1.rx    = rx1;
    assign bus1.ready = ready1;
    assign bus2.rx    = rx2;
    assign bus2.ready = ready2;

    uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_rx dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Observed activity of dut1 and dut2 since the last clear_mon.
    logic [7:0] acc_q[$];
    logic [7:0] acc2_q[$];
    int fe_cnt, ov_cnt, vhigh_cnt, rise_cyc, inv_bad, fe2_cnt, ov2_cnt;
    bit rise_seen;
    bit pv, pr;
    logic [7:0] pd;
    bit rnd_ready;
    int frame_c0;

    initial begin
        pv = 1'b0; pr = 1'b0; pd = 8'h00; inv_bad = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus1.valid && ready1) acc_q.push_back(bus1.dout);
                if (bus1.frame_err) fe_cnt++;
                if (bus1.overrun) ov_cnt++;
                if (bus1.valid) vhigh_cnt++;
                if (bus1.valid && !rise_seen) begin
                    rise_seen = 1'b1;
                    rise_cyc  = cyc;
                end
                if (bus1.frame_err && bus1.overrun) inv_bad++;
                if (pv && !pr && (!bus1.valid || bus1.dout !== pd)) inv_bad++;
                if (bus2.valid && ready2) acc2_q.push_back(bus2.dout);
                if (bus2.frame_err) fe2_cnt++;
                if (bus2.overrun) ov2_cnt++;
                pv = bus1.valid; pr = ready1; pd = bus1.dout;
            end else begin
                pv = 1'b0;
            end
        end
    end

    initial begin
        rnd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) ready1 = 1'($urandom_range(0, 1));
        end
    end

    function automatic void check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    task automatic clear_mon();
        acc_q.delete();
        acc2_q.delete();
        fe_cnt = 0; ov_cnt = 0; vhigh_cnt = 0; fe2_cnt = 0; ov2_cnt = 0;
        rise_seen = 1'b0; rise_cyc = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 1) rx1 = v;
        else            rx2 = v;
    endtask

    // Start bit, 8 data bits LSB first, then a stop bit of the requested level.
    task automatic send(input int which, input logic [7:0] b, input bit stop_ok, input int bc);
        logic [9:0] fr;
        fr = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
        @(posedge clk);
        #1;
        frame_c0 = cyc;
        for (int k = 0; k < 10; k++) begin
            set_rx(which, fr[k]);
            repeat (bc) @(posedge clk);
            #1;
        end
        set_rx(which, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] exp_q[$];
    int exp_fe;
    logic [7:0] rb;
    bit rok;
    int n_cmp;

    initial begin
        vecs[0] = '{data: 8'hA5, stop_ok: 1'b1};
        vecs[1] = '{data: 8'h55, stop_ok: 1'b0};
        vecs[2] = '{data: 8'h01, stop_ok: 1'b1};
        vecs[3] = '{data: 8'hFF, stop_ok: 1'b1};
        vecs[4] = '{data: 8'h00, stop_ok: 1'b1};
        vecs[5] = '{data: 8'h80, stop_ok: 1'b1};
        vecs[6] = '{data: 8'h00, stop_ok: 1'b0};

        n_tests = 0; n_fail = 0;
        rx1 = 1'b1; rx2 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
        rst = 1'b1;
        clear_mon();
        cycles(5);
        check("reset_valid", int'(bus1.valid), 0);
        check("reset_dout", int'(bus1.dout), 8'h00);
        check("reset_frame_err", int'(bus1.frame_err), 0);
        check("reset_overrun", int'(bus1.overrun), 0);
        rst = 1'b0;
        cycles(4);

        // Vector table, ready held high.
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            send(1, vecs[i].data, vecs[i].stop_ok, CPB);
            cycles(2 * CPB);
            check($sformatf("vec%0d_count", i), acc_q.size(), vecs[i].stop_ok ? 1 : 0);
            if (acc_q.size() > 0) check($sformatf("vec%0d_dout", i), int'(acc_q[0]), int'(vecs[i].data));
            check($sformatf("vec%0d_frame_err", i), fe_cnt, vecs[i].stop_ok ? 0 : 1);
            check($sformatf("vec%0d_overrun", i), ov_cnt, 0);
            if (vecs[i].stop_ok) begin
                check($sformatf("vec%0d_latency", i), rise_cyc - frame_c0, (19 * CPB) / 2 + 3);
                check($sformatf("vec%0d_valid_width", i), vhigh_cnt, 1);
            end else begin
                check($sformatf("vec%0d_no_valid", i), vhigh_cnt, 0);
            end
        end

        // Two back-to-back frames with no consumer: the second overruns.
        clear_mon();
        ready1 = 1'b0;
        send(1, 8'h3C, 1'b1, CPB);
        send(1, 8'h7E, 1'b1, CPB);
        cycles(CPB);
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_frame_err", fe_cnt, 0);
        check("ovr_valid_held", int'(bus1.valid), 1);
        check("ovr_dout_kept", int'(bus1.dout), 8'h3C);
        ready1 = 1'b1;
        cycles(2);
        check("ovr_drain_count", acc_q.size(), 1);
        if (acc_q.size() > 0) check("ovr_drain_dout", int'(acc_q[0]), 8'h3C);
        check("ovr_valid_drop", int'(bus1.valid), 0);

        // Short low glitch on an idle line, then a real frame.
        clear_mon();
        rx1 = 1'b0;
        cycles(4);
        rx1 = 1'b1;
        cycles(3 * CPB);
        check("glitch_valid", vhigh_cnt, 0);
        check("glitch_frame_err", fe_cnt, 0);
        send(1, 8'hFF, 1'b1, CPB);
        cycles(2 * CPB);
        check("glitch_next_count", acc_q.size(), 1);
        if (acc_q.size() > 0) check("glitch_next_dout", int'(acc_q[0]), 8'hFF);

        // One-cycle reset during data bit 3 abandons the frame.
        clear_mon();
        fork
            send(1, 8'h81, 1'b1, CPB);
            begin
                cycles(4 * CPB - CPB / 2);
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end
        join
        cycles(2 * CPB);
        check("rst_mid_valid", vhigh_cnt, 0);
        check("rst_mid_frame_err", fe_cnt, 0);
        check("rst_mid_overrun", ov_cnt, 0);
        send(1, 8'h42, 1'b1, CPB);
        cycles(2 * CPB);
        check("rst_next_count", acc_q.size(), 1);
        if (acc_q.size() > 0) check("rst_next_dout", int'(acc_q[0]), 8'h42);

        // Line held low through reset release must not start a frame.
        clear_mon();
        rx1 = 1'b0;
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(12 * CPB);
        check("low_rst_valid", vhigh_cnt, 0);
        check("low_rst_frame_err", fe_cnt, 0);
        rx1 = 1'b1;
        cycles(4);
        send(1, 8'h5A, 1'b1, CPB);
        cycles(2 * CPB);
        check("low_rst_next_count", acc_q.size(), 1);
        if (acc_q.size() > 0) check("low_rst_next_dout", int'(acc_q[0]), 8'h5A);

        // Randomized stream: good frames deliver bytes in order, bad stops count errors.
        clear_mon();
        exp_q.delete();
        exp_fe = 0;
        rnd_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 4) != 0);
            send(1, rb, rok, CPB);
            if (rok) exp_q.push_back(rb);
            else     exp_fe++;
            cycles(rok ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12)));
        end
        rnd_ready = 1'b0;
        cycles(1);
        ready1 = 1'b1;
        cycles(2 * CPB);
        check("rand_count", acc_q.size(), exp_q.size());
        n_cmp = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            check($sformatf("rand_byte%0d", i), int'(acc_q[i]), int'(exp_q[i]));
        end
        check("rand_frame_err", fe_cnt, exp_fe);
        check("rand_overrun", ov_cnt, 0);
        check("invariants", inv_bad, 0);

        // Default divider with +/-2% bit-time skew.
        clear_mon();
        send(2, 8'h00, 1'b1, (CPB2 * 102) / 100);
        cycles(CPB2);
        send(2, 8'hFF, 1'b1, (CPB2 * 98) / 100);
        cycles(CPB2);
        check("skew_count", acc2_q.size(), 2);
        if (acc2_q.size() > 0) check("skew_byte0", int'(acc2_q[0]), 8'h00);
        if (acc2_q.size() > 1) check("skew_byte1", int'(acc2_q[1]), 8'hFF);
        check("skew_frame_err", fe2_cnt, 0);
        check("skew_overrun", ov2_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLOCKS_PER_BAUD, default 2604 (25_000_000 / 9600), clk cycles per bit period; legal range 4..65535.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL provide port dout  output  8  received byte; stable while valid=1.
REQ-006 SHALL provide port valid  output  1  dout holds an unconsumed byte.
REQ-007 SHALL provide port ready  input  1  consumer accepts dout when valid && ready.
REQ-008 SHALL provide port frame_err  output  1  one-cycle pulse when a frame's stop bit samples 0.
REQ-009 SHALL provide port overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; only the synchronized value rx_s feeds logic; both flops reset to 1.
REQ-011 SHALL implement states IDLE, START, DATA, STOP with a down-counter of width ceil(log2(CLOCKS_PER_BAUD)) that counts only outside IDLE.
REQ-012 IDLE: on falling edge of rx_s (previous 1, current 0) SHALL go to START and load counter with CLOCKS_PER_BAUD/2 - 1 (integer divide); a line held low SHALL NOT retrigger.
REQ-013 START: at counter==0, if rx_s==0 SHALL go to DATA, load counter CLOCKS_PER_BAUD - 1, clear bit index; if rx_s==1 (glitch) SHALL return to IDLE with no output activity.
REQ-014 DATA: at each counter==0 SHALL shift rx_s into the MSB of an 8-bit shift register (right shift, so first bit ends at bit 0), increment 3-bit bit index, reload counter; after the 8th sample (index 7) SHALL go to STOP.
REQ-015 STOP: at counter==0 SHALL sample rx_s and return to IDLE in the same transition; rx_s==1 completes a good frame, rx_s==0 pulses frame_err for one cycle and discards the byte.
REQ-016 A good frame SHALL load dout and set valid on the cycle after the stop-bit sample when the holding register is empty or is being consumed that same cycle (valid && ready).
REQ-017 If valid && !ready when a good frame completes, SHALL keep old dout/valid unchanged and pulse overrun for one cycle.
REQ-018 valid SHALL clear the cycle after valid && ready unless REQ-016 reloads in that same cycle, in which case valid stays 1 with new dout.
REQ-019 dout SHALL change only when valid is being set or reloaded; never while valid && !ready.
REQ-020 frame_err and overrun SHALL never assert in the same cycle; a framing-error frame SHALL never cause overrun.
REQ-021 Unreachable state encodings SHALL return to IDLE next cycle.
REQ-022 Receiver SHALL re-arm for the next start bit immediately in IDLE, supporting back-to-back frames with one stop bit.

Reset
REQ-023 On rst SHALL set state IDLE, counter 0, bit index 0, shift register 0, dout 8'h00, valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-024 rst mid-frame SHALL abandon the frame with no valid, frame_err or overrun; the next falling edge after rst deasserts starts a new frame.
REQ-025 With rx held low through reset release, SHALL stay in IDLE until rx rises then falls.

Verification (CLOCKS_PER_BAUD=16 unless stated)
REQ-026 Send 0xA5 with ready=1 -> valid for exactly one cycle, dout=8'hA5, 3 clk after stop-bit center (2 sync + 1), no error pulses.
REQ-027 Send 0x3C then 0x7E back-to-back, ready=0 -> dout=8'h3C valid held, overrun pulses once at second frame end, dout stays 8'h3C; then ready=1 -> valid drops.
REQ-028 Send 0x55 with stop bit forced 0 -> frame_err one-cycle pulse, valid stays 0; next frame 0x01 received correctly after line returns high.
REQ-029 Low glitch of 4 clk on idle rx -> no state beyond START, no valid/frame_err; following 0xFF frame received as 8'hFF.
REQ-030 Assert rst for 1 cycle during bit 3 of 0x81 -> no outputs; next frame 0x42 -> dout=8'h42.
REQ-031 Default CLOCKS_PER_BAUD=2604, send 0x00 and 0xFF at 9600 baud with ±2% bit-time skew -> both received correctly.
